// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer.
// The line and busy flops follow the FSM state one cycle later, so writes show on the line two edges after acceptance.
module uart_tx #(
    parameter int unsigned CLK_FREQ        = 50_000_000,
    parameter int unsigned BAUD_RATE       = 115200,
    parameter int unsigned TX_BUFFER_DEPTH = 32
) (
    input  logic       clk_50mhz,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       buffer_full,
    output logic       buffer_empty,
    output logic       overflow,
    output logic       eos_flag
);

    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int unsigned BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned PTR_W    = $clog2(TX_BUFFER_DEPTH);
    localparam int unsigned CNT_W    = $clog2(TX_BUFFER_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [7:0]        mem [TX_BUFFER_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              push;
    logic              pop;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic              baud_last;
    logic [2:0]        bit_idx;
    logic [7:0]        shift_reg;
    logic              frame_is_eos;

    // A pop happening in the same cycle never frees space for a write.
    assign push      = tx_valid && !buffer_full;
    assign pop       = (state == IDLE) && !buffer_empty;
    assign baud_last = (baud_cnt == BAUD_W'(BAUD_DIV - 1));

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // FIFO storage; contents are meaningless after reset since pointers clear.
    always_ff @(posedge clk_50mhz) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers, occupancy and status flags.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            buffer_full  <= 1'b0;
            buffer_empty <= 1'b1;
            overflow     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count        <= count_nxt;
            buffer_full  <= (count_nxt == CNT_W'(TX_BUFFER_DEPTH));
            buffer_empty <= (count_nxt == '0);
            overflow     <= tx_valid && buffer_full;
        end
    end

    // Serializer FSM; the baud counter restarts on every state entry.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            shift_reg    <= '0;
            frame_is_eos <= 1'b0;
            eos_flag     <= 1'b0;
            tx_out       <= 1'b1;
            tx_busy      <= 1'b0;
        end else begin
            eos_flag <= 1'b0;
            tx_busy  <= (state != IDLE);
            case (state)
                START:   tx_out <= 1'b0;
                DATA:    tx_out <= shift_reg[0];
                default: tx_out <= 1'b1;
            endcase

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (pop) begin
                        shift_reg    <= mem[rd_ptr];
                        frame_is_eos <= (mem[rd_ptr] == 8'h0D) || (mem[rd_ptr] == 8'h0A);
                        state        <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_cnt  <= '0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        eos_flag <= frame_is_eos;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx, run with a 10-cycle bit period to keep frames short.
module tb_uart_tx;

    localparam int DIV   = 10;
    localparam int FRAME = 10 * DIV;

    logic       clk_50mhz;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_out;
    logic       tx_busy;
    logic       buffer_full;
    logic       buffer_empty;
    logic       overflow;
    logic       eos_flag;

    int n_cmp;
    int n_fail;
    int cyc;
    int eos_cnt;
    int eos_cyc;
    int ovf_cnt;

    uart_tx #(
        .CLK_FREQ       (1_000_000),
        .BAUD_RATE      (100_000),
        .TX_BUFFER_DEPTH(32)
    ) dut (
        .clk_50mhz   (clk_50mhz),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_out      (tx_out),
        .tx_busy     (tx_busy),
        .buffer_full (buffer_full),
        .buffer_empty(buffer_empty),
        .overflow    (overflow),
        .eos_flag    (eos_flag)
    );

    initial clk_50mhz = 1'b0;
    always #5 clk_50mhz = ~clk_50mhz;

    initial begin
        cyc     = 0;
        eos_cnt = 0;
        eos_cyc = 0;
        ovf_cnt = 0;
    end

    always @(posedge clk_50mhz) cyc <= cyc + 1;

    always @(negedge clk_50mhz) begin
        if (eos_flag === 1'b1) begin
            eos_cnt = eos_cnt + 1;
            eos_cyc = cyc;
        end
        if (overflow === 1'b1) ovf_cnt = ovf_cnt + 1;
    end

    // Called at a negedge; one write strobe, returns at the following negedge.
    task automatic drive_byte(input logic [7:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk_50mhz);
        tx_valid = 1'b0;
    endtask

    // Finds a start bit and mid-bit samples one frame.
    task automatic rx_frame(output logic [7:0] d, output int s_cyc, output bit to, output bit fr_ok);
        bit found;
        found = 1'b0;
        d     = 8'h00;
        s_cyc = 0;
        fr_ok = 1'b1;
        for (int w = 0; w < 20 * DIV && !found; w++) begin
            @(negedge clk_50mhz);
            if (tx_out === 1'b0) found = 1'b1;
        end
        to = !found;
        if (found) begin
            s_cyc = cyc;
            repeat (DIV / 2) @(negedge clk_50mhz);
            if (tx_out !== 1'b0) fr_ok = 1'b0;
            for (int j = 0; j < 8; j++) begin
                repeat (DIV) @(negedge clk_50mhz);
                d[j] = tx_out;
            end
            repeat (DIV) @(negedge clk_50mhz);
            if (tx_out !== 1'b1) fr_ok = 1'b0;
        end
    endtask

    task automatic wait_idle(output bit to);
        bit done;
        done = 1'b0;
        for (int w = 0; w < 40 * DIV && !done; w++) begin
            @(negedge clk_50mhz);
            if (tx_busy === 1'b0) done = 1'b1;
        end
        to = !done;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk_50mhz);
        n_cmp++; if (tx_out !== 1'b1) begin n_fail++; $display("FAIL rst_tx_out: got %b expected 1", tx_out); end
        n_cmp++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_tx_busy: got %b expected 0", tx_busy); end
        n_cmp++; if (buffer_full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b expected 0", buffer_full); end
        n_cmp++; if (buffer_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b expected 1", buffer_empty); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
        n_cmp++; if (eos_flag !== 1'b0) begin n_fail++; $display("FAIL rst_eos: got %b expected 0", eos_flag); end
        rst_n = 1'b1;
        @(negedge clk_50mhz);
        n_cmp++; if (tx_out !== 1'b1 || buffer_empty !== 1'b1) begin
            n_fail++; $display("FAIL post_rst_idle: tx_out=%b empty=%b expected 1/1", tx_out, buffer_empty);
        end
    endtask

    task automatic test_single_byte;
        logic [9:0] fr;
        int e0;
        bit to;
        fr = {1'b1, 8'h55, 1'b0};
        e0 = eos_cnt;
        drive_byte(8'h55);
        tx_data = 8'hFF;
        n_cmp++; if (tx_out !== 1'b1 || buffer_empty !== 1'b0) begin
            n_fail++; $display("FAIL single_n0: tx_out=%b empty=%b expected 1/0", tx_out, buffer_empty);
        end
        @(negedge clk_50mhz);
        n_cmp++; if (tx_out !== 1'b1 || tx_busy !== 1'b0 || buffer_empty !== 1'b1) begin
            n_fail++; $display("FAIL single_n1: tx_out=%b busy=%b empty=%b expected 1/0/1", tx_out, tx_busy, buffer_empty);
        end
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk_50mhz);
            n_cmp++; if (tx_out !== fr[k / DIV] || tx_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL single_line cycle %0d: tx_out=%b busy=%b expected %b/1", k, tx_out, tx_busy, fr[k / DIV]);
            end
        end
        @(negedge clk_50mhz);
        n_cmp++; if (tx_busy !== 1'b0 || tx_out !== 1'b1) begin
            n_fail++; $display("FAIL single_end: busy=%b tx_out=%b expected 0/1", tx_busy, tx_out);
        end
        n_cmp++; if (eos_cnt - e0 != 0) begin n_fail++; $display("FAIL single_eos: got %0d pulses expected 0", eos_cnt - e0); end
        wait_idle(to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL single_idle_timeout: busy=%b expected 0", tx_busy); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] got [4];
        int st [4];
        bit tos [4];
        bit oks [4];
        bit to;
        fork
            begin
                for (int i = 0; i < 4; i++) drive_byte(8'(8'h10 + i));
            end
            begin
                for (int i = 0; i < 4; i++) rx_frame(got[i], st[i], tos[i], oks[i]);
            end
        join
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (tos[i] || got[i] !== 8'(8'h10 + i) || !oks[i]) begin
                n_fail++; $display("FAIL b2b_frame %0d: got %h to=%0d ok=%0d expected %h", i, got[i], tos[i], oks[i], 8'(8'h10 + i));
            end
            if (i > 0) begin
                n_cmp++; if (st[i] - st[i-1] != FRAME + 1) begin
                    n_fail++; $display("FAIL b2b_period %0d: got %0d expected %0d", i, st[i] - st[i-1], FRAME + 1);
                end
            end
        end
        n_cmp++; if (buffer_empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty: got %b expected 1", buffer_empty); end
        wait_idle(to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL b2b_idle_timeout: busy=%b expected 0", tx_busy); end
    endtask

    task automatic test_overflow;
        logic [7:0] exp_d [33];
        logic [7:0] got [33];
        int st [33];
        bit tos [33];
        bit oks [33];
        int o0;
        bit to;
        exp_d[0] = 8'h80;
        for (int i = 0; i < 32; i++) exp_d[i+1] = 8'(8'hC3 ^ (i * 5));
        o0 = ovf_cnt;
        fork
            begin
                drive_byte(8'h80);
                @(negedge clk_50mhz);
                for (int i = 0; i < 33; i++) begin
                    tx_valid = 1'b1;
                    tx_data  = (i < 32) ? exp_d[i+1] : 8'hEE;
                    @(negedge clk_50mhz);
                    if (i == 30) begin
                        n_cmp++; if (buffer_full !== 1'b0) begin n_fail++; $display("FAIL ovf_full_31: got %b expected 0", buffer_full); end
                    end
                    if (i == 31) begin
                        n_cmp++; if (buffer_full !== 1'b1 || overflow !== 1'b0) begin
                            n_fail++; $display("FAIL ovf_full_32: full=%b ovf=%b expected 1/0", buffer_full, overflow);
                        end
                    end
                    if (i == 32) begin
                        n_cmp++; if (overflow !== 1'b1 || buffer_full !== 1'b1) begin
                            n_fail++; $display("FAIL ovf_pulse: ovf=%b full=%b expected 1/1", overflow, buffer_full);
                        end
                    end
                end
                tx_valid = 1'b0;
                @(negedge clk_50mhz);
                n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pulse_end: got %b expected 0", overflow); end
            end
            begin
                for (int i = 0; i < 33; i++) rx_frame(got[i], st[i], tos[i], oks[i]);
            end
        join
        for (int i = 0; i < 33; i++) begin
            n_cmp++; if (tos[i] || got[i] !== exp_d[i] || !oks[i]) begin
                n_fail++; $display("FAIL ovf_frame %0d: got %h to=%0d ok=%0d expected %h", i, got[i], tos[i], oks[i], exp_d[i]);
            end
        end
        n_cmp++; if (ovf_cnt - o0 != 1) begin n_fail++; $display("FAIL ovf_count: got %0d expected 1", ovf_cnt - o0); end
        wait_idle(to);
        n_cmp++; if (to || buffer_empty !== 1'b1) begin
            n_fail++; $display("FAIL ovf_drain: to=%0d empty=%b expected 0/1", to, buffer_empty);
        end
    endtask

    task automatic test_eos;
        logic [7:0] got [2];
        int st [2];
        bit tos [2];
        bit oks [2];
        int e0;
        bit to;
        e0 = eos_cnt;
        fork
            begin
                drive_byte(8'h41);
                drive_byte(8'h0D);
            end
            begin
                for (int i = 0; i < 2; i++) rx_frame(got[i], st[i], tos[i], oks[i]);
            end
        join
        wait_idle(to);
        repeat (2) @(negedge clk_50mhz);
        n_cmp++; if (tos[0] || tos[1] || got[0] !== 8'h41 || got[1] !== 8'h0D) begin
            n_fail++; $display("FAIL eos_frames: got %h %h expected 41 0d", got[0], got[1]);
        end
        n_cmp++; if (eos_cnt - e0 != 1) begin n_fail++; $display("FAIL eos_count: got %0d expected 1", eos_cnt - e0); end
        n_cmp++; if (eos_cyc != st[1] + FRAME - 1) begin
            n_fail++; $display("FAIL eos_timing: got cycle %0d expected %0d", eos_cyc, st[1] + FRAME - 1);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] got [8];
        int st [8];
        bit tos [8];
        bit oks [8];
        bit to;
        for (int b = 0; b < 5; b++) begin
            fork
                begin
                    for (int i = 0; i < 8; i++) drive_byte(8'(8'h30 + b * 8 + i));
                end
                begin
                    for (int i = 0; i < 8; i++) rx_frame(got[i], st[i], tos[i], oks[i]);
                end
            join
            for (int i = 0; i < 8; i++) begin
                n_cmp++; if (tos[i] || got[i] !== 8'(8'h30 + b * 8 + i) || !oks[i]) begin
                    n_fail++; $display("FAIL wrap_frame %0d.%0d: got %h expected %h", b, i, got[i], 8'(8'h30 + b * 8 + i));
                end
            end
            wait_idle(to);
            n_cmp++; if (to || buffer_empty !== 1'b1) begin
                n_fail++; $display("FAIL wrap_drain %0d: to=%0d empty=%b expected 0/1", b, to, buffer_empty);
            end
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] got;
        int st;
        bit to;
        bit ok;
        bit found;
        int e0;
        e0 = eos_cnt;
        found = 1'b0;
        drive_byte(8'hAA);
        drive_byte(8'h77);
        for (int w = 0; w < 10 && !found; w++) begin
            @(negedge clk_50mhz);
            if (tx_out === 1'b0) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_fail++; $display("FAIL rstmid_start: tx_out=%b expected 0", tx_out); end
        repeat (4 * DIV + DIV / 2) @(negedge clk_50mhz);
        n_cmp++; if (tx_busy !== 1'b1 || buffer_empty !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_pre: busy=%b empty=%b expected 1/0", tx_busy, buffer_empty);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (tx_out !== 1'b1 || tx_busy !== 1'b0 || buffer_empty !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_async: tx_out=%b busy=%b empty=%b expected 1/0/1", tx_out, tx_busy, buffer_empty);
        end
        repeat (2) @(negedge clk_50mhz);
        rst_n = 1'b1;
        fork
            drive_byte(8'h5A);
            rx_frame(got, st, to, ok);
        join
        n_cmp++; if (to || got !== 8'h5A || !ok) begin
            n_fail++; $display("FAIL rstmid_frame: got %h to=%0d ok=%0d expected 5a", got, to, ok);
        end
        wait_idle(to);
        repeat (3 * DIV) @(negedge clk_50mhz);
        n_cmp++; if (tx_busy !== 1'b0 || buffer_empty !== 1'b1 || tx_out !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_after: busy=%b empty=%b tx_out=%b expected 0/1/1", tx_busy, buffer_empty, tx_out);
        end
        n_cmp++; if (eos_cnt - e0 != 0) begin n_fail++; $display("FAIL rstmid_eos: got %0d expected 0", eos_cnt - e0); end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_eos();
        test_wrap();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d compared so far", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
